// File: rtl/siw_agu_pkg.sv
// Shared definitions for the siw address-generator blocks: FSM state type
// and default widths.
package siw_agu_pkg;

  localparam int unsigned AGU_ADDR_W  = 10;
  localparam int unsigned AGU_CNT_W   = 10;
  localparam int unsigned AGU_DELAY_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } agu_state_e;

endpackage : siw_agu_pkg

// File: rtl/siw_agu_loop_cnt.sv
// Wrap-detecting loop counter: counts 0..last_i while enabled, then wraps to 0.
module siw_agu_loop_cnt #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == last_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : siw_agu_loop_cnt

// File: rtl/siw_addrgen_7.sv
// Two-level (iter x per) BRAM address generator with start delay; all outputs
// are registered and driven from a config latched at init.
module siw_addrgen_7
  import siw_agu_pkg::*;
#(
  parameter int unsigned ADDR_W  = AGU_ADDR_W,
  parameter int unsigned CNT_W   = AGU_CNT_W,
  parameter int unsigned DELAY_W = AGU_DELAY_W
) (
  input  logic               siw_addrgen_7_clk,
  input  logic               siw_addrgen_7_reset_n,
  input  logic               siw_addrgen_7_init,
  input  logic               siw_addrgen_7_run,
  input  logic [ADDR_W-1:0]  siw_addrgen_7_start,
  input  logic [ADDR_W-1:0]  siw_addrgen_7_incr,
  input  logic [ADDR_W-1:0]  siw_addrgen_7_shift,
  input  logic [CNT_W-1:0]   siw_addrgen_7_per,
  input  logic [CNT_W-1:0]   siw_addrgen_7_iter,
  input  logic [DELAY_W-1:0] siw_addrgen_7_delay,
  input  logic               siw_addrgen_7_rnw,
  output logic [ADDR_W-1:0]  siw_addrgen_7_addr,
  output logic               siw_addrgen_7_enable,
  output logic               siw_addrgen_7_write_en,
  output logic               siw_addrgen_7_busy,
  output logic               siw_addrgen_7_done
);

  agu_state_e         state_q;
  logic [ADDR_W-1:0]  start_q, incr_q, shift_q, addr_q;
  logic [CNT_W-1:0]   per_q, iter_q;
  logic [DELAY_W-1:0] delay_q, dcnt_q;
  logic               rnw_q, en_q, we_q, busy_q, done_q;

  logic run_go, loops_empty, cnt_clr, j_wrap, i_wrap, last_access;

  assign loops_empty = (per_q == '0) || (iter_q == '0);
  assign run_go      = siw_addrgen_7_run && !siw_addrgen_7_init &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cnt_clr     = siw_addrgen_7_init || run_go;
  assign last_access = j_wrap && i_wrap;

  siw_agu_loop_cnt #(.W(CNT_W)) u_cnt_j (
    .clk_i  (siw_addrgen_7_clk),
    .rst_ni (siw_addrgen_7_reset_n),
    .clr_i  (cnt_clr),
    .en_i   (state_q == ST_RUN),
    .last_i (per_q - CNT_W'(1)),
    .wrap_o (j_wrap)
  );

  siw_agu_loop_cnt #(.W(CNT_W)) u_cnt_i (
    .clk_i  (siw_addrgen_7_clk),
    .rst_ni (siw_addrgen_7_reset_n),
    .clr_i  (cnt_clr),
    .en_i   ((state_q == ST_RUN) && j_wrap),
    .last_i (iter_q - CNT_W'(1)),
    .wrap_o (i_wrap)
  );

  always_ff @(posedge siw_addrgen_7_clk or negedge siw_addrgen_7_reset_n) begin
    if (!siw_addrgen_7_reset_n) begin
      state_q <= ST_IDLE;
      start_q <= '0;
      incr_q  <= '0;
      shift_q <= '0;
      per_q   <= '0;
      iter_q  <= '0;
      delay_q <= '0;
      rnw_q   <= 1'b0;
      dcnt_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (siw_addrgen_7_init) begin
      start_q <= siw_addrgen_7_start;
      incr_q  <= siw_addrgen_7_incr;
      shift_q <= siw_addrgen_7_shift;
      per_q   <= siw_addrgen_7_per;
      iter_q  <= siw_addrgen_7_iter;
      delay_q <= siw_addrgen_7_delay;
      rnw_q   <= siw_addrgen_7_rnw;
      addr_q  <= siw_addrgen_7_start;
      dcnt_q  <= '0;
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (run_go) begin
            addr_q <= start_q;
            done_q <= 1'b0;
            if (delay_q != '0) begin
              state_q <= ST_DELAY;
              dcnt_q  <= delay_q;
              busy_q  <= 1'b1;
            end else if (loops_empty) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              en_q    <= 1'b1;
              we_q    <= ~rnw_q;
            end
          end
        end
        ST_DELAY: begin
          dcnt_q <= dcnt_q - DELAY_W'(1);
          if (dcnt_q == DELAY_W'(1)) begin
            if (loops_empty) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              en_q    <= 1'b1;
              we_q    <= ~rnw_q;
            end
          end
        end
        ST_RUN: begin
          // the outer-loop shift is folded into the step taken as j wraps
          addr_q <= addr_q + incr_q + (j_wrap ? shift_q : '0);
          if (last_access) begin
            state_q <= ST_DONE;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign siw_addrgen_7_addr     = addr_q;
  assign siw_addrgen_7_enable   = en_q;
  assign siw_addrgen_7_write_en = we_q;
  assign siw_addrgen_7_busy     = busy_q;
  assign siw_addrgen_7_done     = done_q;

endmodule : siw_addrgen_7

// File: tb/tb_siw_addrgen_7.sv
// Bench for siw_addrgen_7: per-cycle comparison against a queue-based model of
// the expected access stream, plus directed literal checks.
module tb_siw_addrgen_7;

  localparam int AW = 10;
  localparam int CW = 10;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          init = 1'b0, run = 1'b0, rnw = 1'b0;
  logic [AW-1:0] start = '0, incr = '0, shift = '0;
  logic [CW-1:0] per = '0, iter = '0;
  logic [DW-1:0] delay = '0;
  logic [AW-1:0] addr;
  logic          en, we, busy, done;

  siw_addrgen_7 #(.ADDR_W(AW), .CNT_W(CW), .DELAY_W(DW)) dut (
    .siw_addrgen_7_clk      (clk),
    .siw_addrgen_7_reset_n  (rst_n),
    .siw_addrgen_7_init     (init),
    .siw_addrgen_7_run      (run),
    .siw_addrgen_7_start    (start),
    .siw_addrgen_7_incr     (incr),
    .siw_addrgen_7_shift    (shift),
    .siw_addrgen_7_per      (per),
    .siw_addrgen_7_iter     (iter),
    .siw_addrgen_7_delay    (delay),
    .siw_addrgen_7_rnw      (rnw),
    .siw_addrgen_7_addr     (addr),
    .siw_addrgen_7_enable   (en),
    .siw_addrgen_7_write_en (we),
    .siw_addrgen_7_busy     (busy),
    .siw_addrgen_7_done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic          addr_v;
    logic [AW-1:0] addr;
    logic          en;
    logic          we;
    logic          busy;
    logic          done;
  } exp_t;

  function automatic exp_t mk(input logic av, input logic [AW-1:0] a,
                              input logic e, input logic w, input logic b, input logic d);
    exp_t r;
    r.addr_v = av; r.addr = a; r.en = e; r.we = w; r.busy = b; r.done = d;
    return r;
  endfunction

  // Address of access number k: k inner steps plus one shift per completed period.
  function automatic logic [AW-1:0] acc_addr(input int unsigned s, input int unsigned inc,
                                             input int unsigned sh, input int unsigned per_v,
                                             input int unsigned k);
    int unsigned a;
    a = s + k * inc + (k / per_v) * sh;
    return a[AW-1:0];
  endfunction

  exp_t          cur = '0;
  exp_t          q[$];
  logic [AW-1:0] m_start = '0, m_incr = '0, m_shift = '0;
  logic [CW-1:0] m_per = '0, m_iter = '0;
  logic [DW-1:0] m_delay = '0;
  logic          m_rnw = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_start = '0; m_incr = '0; m_shift = '0; m_per = '0; m_iter = '0;
        m_delay = '0; m_rnw = 1'b0;
        q.delete();
        cur = mk(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (init) begin
        m_start = start; m_incr = incr; m_shift = shift; m_per = per; m_iter = iter;
        m_delay = delay; m_rnw = rnw;
        q.delete();
        cur = mk(1'b1, start, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (run && !cur.busy) begin
        q.delete();
        for (int unsigned d = 0; d < m_delay; d++)
          q.push_back(mk(1'b1, m_start, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int unsigned k = 0; k < m_per * m_iter; k++)
          q.push_back(mk(1'b1, acc_addr(m_start, m_incr, m_shift, m_per, k),
                         1'b1, ~m_rnw, 1'b1, 1'b0));
        cur = (q.size() != 0) ? q.pop_front() : mk(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      end else if (cur.busy) begin
        cur = (q.size() != 0) ? q.pop_front() : mk(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
    end
  end

  // ---------------- compare + capture ----------------
  logic [AW-1:0] cap[$];
  int            first_en_cyc = -1;

  initial begin
    forever begin
      @(negedge clk);
      check("cycle", {12'd0, (cur.addr_v ? addr : {AW{1'b0}}), en, we, busy, done},
                     {12'd0, (cur.addr_v ? cur.addr : {AW{1'b0}}), cur.en, cur.we, cur.busy, cur.done});
      if (en) begin
        if (cap.size() == 0) first_en_cyc = cyc;
        cap.push_back(addr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int run_cyc  = 0;
  int done_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int unsigned s, input int unsigned i, input int unsigned sh,
                     input int unsigned p, input int unsigned it, input int unsigned d,
                     input logic r);
    start = AW'(s); incr = AW'(i); shift = AW'(sh); per = CW'(p); iter = CW'(it);
    delay = DW'(d); rnw = r;
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic go();
    cap.delete();
    first_en_cyc = -1;
    run = 1'b1;
    run_cyc = cyc;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    done_cyc = cyc;
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic check_cap(input string name, input int unsigned exp_a[]);
    check({name, "_count"}, cap.size(), exp_a.size());
    for (int k = 0; k < exp_a.size() && k < cap.size(); k++)
      check(name, {22'd0, cap[k]}, exp_a[k]);
  endtask

  // ---------------- main ----------------
  initial begin
    int unsigned e1[] = '{4, 5, 6, 7, 8};
    int unsigned e2[] = '{0, 1, 8, 9, 16, 17};
    int unsigned e5[] = '{1022, 1023, 0, 1};
    int unsigned e6[] = '{100, 103, 106};
    int unsigned none[] = '{};

    #1 rst_n = 1'b0;
    #3;
    check("reset_outputs", {22'd0, addr, en, we, busy, done}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // model anchoring: period step and wrap arithmetic
    for (int k = 0; k < 6; k++) check("model_shift", {22'd0, acc_addr(0, 1, 6, 2, k)}, e2[k]);
    for (int k = 0; k < 4; k++) check("model_wrap", {22'd0, acc_addr(1022, 1, 0, 4, k)}, e5[k]);

    // 1: simple read sequence
    cfg(4, 1, 0, 5, 1, 0, 1'b1);
    go();
    wait_done(20);
    check_cap("t1_addr", e1);
    check("t1_first_en", first_en_cyc - run_cyc, 1);
    check("t1_done_lat", done_cyc - run_cyc, 6);

    // 2: outer-loop shift
    cfg(0, 1, 6, 2, 3, 0, 1'b1);
    go();
    wait_done(20);
    check_cap("t2_addr", e2);

    // 3: start delay
    cfg(10, 2, 0, 3, 1, 3, 1'b1);
    go();
    wait_done(20);
    check("t3_first_en", first_en_cyc - run_cyc, 4);

    // 4: empty loops
    cfg(7, 1, 0, 0, 3, 0, 1'b1);
    go();
    wait_done(10);
    check("t4a_done_lat", done_cyc - run_cyc, 1);
    check_cap("t4a_addr", none);
    cfg(7, 1, 0, 5, 0, 0, 1'b0);
    go();
    wait_done(10);
    check("t4b_done_lat", done_cyc - run_cyc, 1);
    check_cap("t4b_addr", none);

    // 5: wrap with writes
    cfg(1022, 1, 0, 4, 1, 0, 1'b0);
    go();
    wait_done(20);
    check_cap("t5_addr", e5);

    // 6: run while busy ignored, init aborts mid-run
    cfg(100, 3, 0, 4, 3, 0, 1'b1);
    go();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    start = AW'(500);
    init = 1'b1;
    tick();
    init = 1'b0;
    #2;
    check("t6_en_after_init", {31'd0, en}, 32'd0);
    check("t6_addr_after_init", {22'd0, addr}, 32'd500);
    check("t6_busy_after_init", {31'd0, busy}, 32'd0);
    check_cap("t6_addr", e6);

    // 7: asynchronous reset mid-run
    cfg(50, 1, 0, 6, 4, 0, 1'b0);
    go();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_reset", {22'd0, addr, en, we, busy, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic: inputs change every cycle, init latches them
    for (int c = 0; c < 1500; c++) begin
      start = AW'($urandom);
      incr  = AW'($urandom);
      shift = AW'($urandom);
      per   = CW'($urandom_range(0, 5));
      iter  = CW'($urandom_range(0, 4));
      delay = ($urandom_range(0, 9) == 0) ? DW'(20) : DW'($urandom_range(0, 3));
      rnw   = 1'($urandom);
      init  = ($urandom_range(0, 24) == 0);
      run   = ($urandom_range(0, 3) == 0);
      tick();
    end
    init = 1'b0;
    run  = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_siw_addrgen_7
